// File: rtl/extmem_burst_master_if.sv
// Bundle of command, external-memory and stream signals for
// extmem_burst_master; master side is the burst engine.
`ifndef DATA_EXT_RAM
`define DATA_EXT_RAM 32
`endif
`ifndef ADDR_EXT_RAM
`define ADDR_EXT_RAM 20
`endif

interface extmem_burst_master_if #(
    parameter int DATA_W = `DATA_EXT_RAM,
    parameter int ADDR_W = `ADDR_EXT_RAM,
    parameter int LEN_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              mem_re;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_dir, cmd_addr, cmd_len,
        input  mem_rd_data, rd_ready, wr_valid, wr_data,
        output cmd_ready, mem_re, mem_rd_addr,
        output mem_we, mem_wr_addr, mem_wr_data,
        output rd_valid, rd_data, rd_last, wr_ready,
        output busy, done
    );

    modport slave (
        output cmd_valid, cmd_dir, cmd_addr, cmd_len,
        output mem_rd_data, rd_ready, wr_valid, wr_data,
        input  cmd_ready, mem_re, mem_rd_addr,
        input  mem_we, mem_wr_addr, mem_wr_data,
        input  rd_valid, rd_data, rd_last, wr_ready,
        input  busy, done
    );
endinterface

// File: rtl/extmem_burst_master.sv
// Burst engine moving words between an external memory and
// valid/ready read/write streams, with a 4-deep read buffer.
`ifndef DATA_EXT_RAM
`define DATA_EXT_RAM 32
`endif
`ifndef ADDR_EXT_RAM
`define ADDR_EXT_RAM 20
`endif

module extmem_burst_master #(
    parameter int DATA_W = `DATA_EXT_RAM,
    parameter int ADDR_W = `ADDR_EXT_RAM,
    parameter int LEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    extmem_burst_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  iss_cnt;
    logic [LEN_W-1:0]  pop_cnt;
    logic [LEN_W-1:0]  acc_cnt;
    logic              pend_q;

    logic [DATA_W-1:0] fifo_mem [4];
    logic [1:0]        wptr;
    logic [1:0]        rptr;
    logic [2:0]        count;

    logic accept, issue, push, pop, last_pop, wr_hs;

    assign accept   = bus.cmd_valid && (state == IDLE);
    assign push     = pend_q;
    assign pop      = bus.rd_valid && bus.rd_ready;
    assign last_pop = pop && bus.rd_last;
    assign wr_hs    = bus.wr_valid && bus.wr_ready;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.rd_valid  = (count != 3'd0);
    assign bus.rd_data   = fifo_mem[rptr];
    assign bus.rd_last   = (count != 3'd0) &&
                           (pop_cnt == len_q - LEN_W'(1));
    assign bus.wr_ready  = (state == WRITE) && (acc_cnt < len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Buffer occupancy plus reads still in the memory pipe must stay
    // below 4 so a newly issued read always finds a free slot.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0) begin
                        state_nx = FIN;
                    end else if (bus.cmd_dir) begin
                        state_nx = WRITE;
                    end else begin
                        state_nx = READ;
                        issue    = 1'b1;
                    end
                end
            end
            READ: begin
                issue = (iss_cnt < len_q) &&
                        ((count + {2'b0, bus.mem_re} +
                          {2'b0, pend_q}) < 3'd4);
                if (last_pop) state_nx = FIN;
            end
            WRITE: begin
                if (bus.mem_we && (acc_cnt == len_q)) state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q          <= '0;
            len_q           <= '0;
            iss_cnt         <= '0;
            pop_cnt         <= '0;
            acc_cnt         <= '0;
            pend_q          <= 1'b0;
            bus.mem_re      <= 1'b0;
            bus.mem_rd_addr <= '0;
        end else begin
            pend_q     <= bus.mem_re;
            bus.mem_re <= issue;
            if (accept) begin
                base_q  <= bus.cmd_addr;
                len_q   <= bus.cmd_len;
                pop_cnt <= '0;
            end else if (pop) begin
                pop_cnt <= pop_cnt + LEN_W'(1);
            end
            if (accept) begin
                iss_cnt         <= issue ? LEN_W'(1) : '0;
                bus.mem_rd_addr <= bus.cmd_addr;
            end else if (issue) begin
                iss_cnt         <= iss_cnt + LEN_W'(1);
                bus.mem_rd_addr <= base_q + ADDR_W'(iss_cnt);
            end
            if (accept) begin
                acc_cnt <= '0;
            end else if (wr_hs) begin
                acc_cnt <= acc_cnt + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wptr] <= bus.mem_rd_data;
                wptr           <= wptr + 2'd1;
            end
            if (pop) rptr <= rptr + 2'd1;
            count <= count + {2'b0, push} - {2'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_we      <= 1'b0;
            bus.mem_wr_addr <= '0;
            bus.mem_wr_data <= '0;
        end else begin
            bus.mem_we <= wr_hs;
            if (wr_hs) begin
                bus.mem_wr_addr <= base_q + ADDR_W'(acc_cnt);
                bus.mem_wr_data <= bus.wr_data;
            end
        end
    end
endmodule

// File: tb/tb_extmem_burst_master.sv
// Directed and randomized bursts against an external memory model
// and a queue-based reference of expected addresses and data.
module tb_extmem_burst_master;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int LW = 8;
    localparam int MN = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b0;
    always #5 clk = ~clk;

    extmem_burst_master_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus();

    extmem_burst_master #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [DW-1:0] ext_mem [MN];
    logic [DW-1:0] ref_mem [MN];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < MN; i++) ext_mem[i] <= ref_mem[i];
            bus.mem_rd_data <= '0;
        end else begin
            if (bus.mem_re) bus.mem_rd_data <= ext_mem[bus.mem_rd_addr];
            if (bus.mem_we) ext_mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int acc_cyc, acc_n, first_rv_cyc, re_total, pop_total;
    int re_addr_q[$];
    int we_addr_q[$], we_data_q[$], we_cyc_q[$], hs_cyc_q[$];
    int rd_data_q[$], rd_last_q[$], rd_cyc_q[$];
    int done_cyc_q[$];
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cyc = cyc;
                acc_n++;
            end
            if (bus.mem_re) begin
                re_addr_q.push_back(int'(bus.mem_rd_addr));
                re_total++;
            end
            if (bus.mem_we) begin
                we_addr_q.push_back(int'(bus.mem_wr_addr));
                we_data_q.push_back(int'(bus.mem_wr_data));
                we_cyc_q.push_back(cyc);
            end
            if (bus.wr_valid && bus.wr_ready) hs_cyc_q.push_back(cyc);
            if (bus.rd_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
            if (prev_stall) begin
                chk("stall_valid", bus.rd_valid, 1);
                chk("stall_data", bus.rd_data, prev_data);
                chk("stall_last", bus.rd_last, prev_last);
            end
            chk("outstanding_le4", (re_total - pop_total) <= 4, 1);
            if (bus.rd_valid && bus.rd_ready) begin
                rd_data_q.push_back(int'(bus.rd_data));
                rd_last_q.push_back(int'(bus.rd_last));
                rd_cyc_q.push_back(cyc);
                pop_total++;
            end
            if (bus.done) done_cyc_q.push_back(cyc);
            chk("re_we_excl", bus.mem_re && bus.mem_we, 0);
            chk("idle_fin_quiet",
                (!bus.busy || bus.done) && (bus.mem_re || bus.mem_we), 0);
            prev_stall = bus.rd_valid && !bus.rd_ready;
            prev_data  = bus.rd_data;
            prev_last  = bus.rd_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        re_addr_q.delete(); we_addr_q.delete(); we_data_q.delete();
        we_cyc_q.delete(); hs_cyc_q.delete(); rd_data_q.delete();
        rd_last_q.delete(); rd_cyc_q.delete(); done_cyc_q.delete();
        acc_n = 0; acc_cyc = -100; first_rv_cyc = -1;
        re_total = 0; pop_total = 0;
    endtask

    function automatic logic ready_of(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 4 == 0) || (c % 4 == 3);
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic garbage_cmd(input bit en);
        bus.cmd_valid = en && bus.busy && !bus.done &&
                        ($urandom_range(0, 1) == 1);
        bus.cmd_dir  = logic'($urandom_range(0, 1));
        bus.cmd_addr = AW'($urandom);
        bus.cmd_len  = LW'($urandom);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_mem_re"}, bus.mem_re, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_rd_valid"}, bus.rd_valid, 0);
        chk({tag, "_rd_last"}, bus.rd_last, 0);
        chk({tag, "_wr_ready"}, bus.wr_ready, 0);
        chk({tag, "_rd_addr"}, bus.mem_rd_addr, 0);
        chk({tag, "_wr_addr"}, bus.mem_wr_addr, 0);
        chk({tag, "_wr_data"}, bus.mem_wr_data, 0);
        chk({tag, "_rd_data"}, bus.rd_data, 0);
    endtask

    task automatic finish_burst(input bit got);
        chk("done_seen", got, 1);
        bus.cmd_valid = 1'b0;
        bus.rd_ready  = 1'b0;
        bus.wr_valid  = 1'b0;
        tick();
        chk("ready_after_fin", bus.cmd_ready, 1);
        chk("done_single", bus.done, 0);
        tick();
        chk("done_once", done_cyc_q.size(), 1);
        chk("accept_once", acc_n, 1);
    endtask

    task automatic run_read(input int a, input int len, input int mode,
                            input bit ign);
        int exp_q[$];
        int c;
        bit got;
        clear_logs();
        for (int i = 0; i < len; i++) exp_q.push_back(int'(ref_mem[(a + i) % MN]));
        bus.cmd_dir   = 1'b0;
        bus.cmd_addr  = AW'(a);
        bus.cmd_len   = LW'(len);
        bus.cmd_valid = 1'b1;
        bus.rd_ready  = ready_of(mode, 0);
        chk("rd_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        got = 1'b0;
        c = 1;
        while (c < 400) begin
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            bus.rd_ready = ready_of(mode, c);
            garbage_cmd(ign);
            tick();
            c++;
        end
        finish_burst(got);
        chk("rd_re_count", re_addr_q.size(), len);
        for (int i = 0; i < len && i < re_addr_q.size(); i++)
            chk("rd_re_addr", re_addr_q[i], (a + i) % MN);
        chk("rd_beats", rd_data_q.size(), len);
        for (int i = 0; i < len && i < rd_data_q.size(); i++) begin
            chk("rd_data", rd_data_q[i], exp_q[i]);
            chk("rd_last", rd_last_q[i], int'(i == len - 1));
        end
        if (len == 0 && done_cyc_q.size() > 0)
            chk("zero_done_timing", done_cyc_q[0], acc_cyc + 1);
        if (len > 0 && rd_cyc_q.size() == len && done_cyc_q.size() > 0)
            chk("rd_done_timing", done_cyc_q[0], rd_cyc_q[len-1] + 1);
        if (mode == 0 && len > 0) begin
            chk("rd_first_lat", first_rv_cyc - acc_cyc, 3);
            for (int i = 0; i < rd_cyc_q.size(); i++)
                chk("rd_back2back", rd_cyc_q[i], acc_cyc + 3 + i);
        end
    endtask

    task automatic run_write(input int a, input int len,
                             input logic [DW-1:0] d[$], input bit gaps,
                             input bit ign);
        int c;
        int idx;
        bit got;
        bit hs;
        clear_logs();
        bus.cmd_dir   = 1'b1;
        bus.cmd_addr  = AW'(a);
        bus.cmd_len   = LW'(len);
        bus.cmd_valid = 1'b1;
        chk("wr_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        got = 1'b0;
        idx = 0;
        c = 1;
        while (c < 400) begin
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            bus.wr_valid = (idx < len) &&
                           (!gaps || $urandom_range(0, 1) == 1);
            bus.wr_data  = (idx < len) ? d[idx] : '0;
            hs = bus.wr_valid && bus.wr_ready;
            garbage_cmd(ign);
            tick();
            if (hs) idx++;
            c++;
        end
        finish_burst(got);
        for (int i = 0; i < len; i++) ref_mem[(a + i) % MN] = d[i];
        chk("wr_we_count", we_addr_q.size(), len);
        for (int i = 0; i < len && i < we_addr_q.size(); i++) begin
            chk("wr_addr", we_addr_q[i], (a + i) % MN);
            chk("wr_data", we_data_q[i], int'(d[i]));
            if (i < hs_cyc_q.size())
                chk("wr_we_timing", we_cyc_q[i], hs_cyc_q[i] + 1);
        end
        if (len == 0 && done_cyc_q.size() > 0)
            chk("zero_done_timing", done_cyc_q[0], acc_cyc + 1);
        if (len > 0 && we_cyc_q.size() == len && done_cyc_q.size() > 0)
            chk("wr_done_timing", done_cyc_q[0], we_cyc_q[len-1] + 1);
    endtask

    logic [DW-1:0] dq[$];
    logic [DW-1:0] eq[$];

    initial begin
        int c;
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.rd_ready  = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        for (int i = 0; i < MN; i++) ref_mem[i] = DW'($urandom);
        for (int i = 0; i < 4; i++) ref_mem[16 + i] = DW'(i + 1);
        clear_logs();
        load = 1'b1;
        #2;
        chk_reset_outs("por");
        tick();
        tick();
        load = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();

        run_read(16, 4, 0, 0);
        run_read(64, 6, 1, 0);

        dq = {16'h000A, 16'h000B, 16'h000C};
        run_write(32, 3, dq, 1, 0);
        run_read(32, 3, 0, 0);

        run_read(85, 0, 0, 0);
        run_write(102, 0, eq, 0, 0);

        run_read(MN - 2, 4, 0, 0);

        clear_logs();
        bus.cmd_dir   = 1'b0;
        bus.cmd_addr  = AW'(128);
        bus.cmd_len   = LW'(8);
        bus.cmd_valid = 1'b1;
        bus.rd_ready  = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        c = 0;
        while (rd_data_q.size() < 2 && c < 50) begin
            tick();
            c++;
        end
        chk("rst_two_beats", rd_data_q.size(), 2);
        if (rd_data_q.size() >= 2) begin
            chk("rst_beat0", rd_data_q[0], int'(ref_mem[128]));
            chk("rst_beat1", rd_data_q[1], int'(ref_mem[129]));
        end
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        tick();
        chk_reset_outs("midrst_hold");
        rst_n = 1'b1;
        bus.rd_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_rd_valid", bus.rd_valid, 0);
            chk("post_rst_mem_re", bus.mem_re, 0);
        end
        chk("post_rst_no_beats", rd_data_q.size(), 0);
        run_read(48, 2, 0, 0);

        for (int k = 0; k < 10; k++) begin
            int a;
            int len;
            a   = int'($urandom_range(0, MN - 1));
            len = int'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) begin
                dq.delete();
                for (int i = 0; i < len; i++) dq.push_back(DW'($urandom));
                run_write(a, len, dq, 1, 1);
            end else begin
                run_read(a, len, int'($urandom_range(0, 2)), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/extmem_burst_master.md
EXTMEM_BURST_MASTER -- requirements
Module: extmem_burst_master

Interface
REQ-001 Parameter DATA_W, default `DATA_EXT_RAM, external memory word width.
REQ-002 Parameter ADDR_W, default `ADDR_EXT_RAM, external memory address width.
REQ-003 Parameter LEN_W, default 16, burst length field width in beats.
REQ-004 Clocking and reset SHALL be exactly: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-009 cmd_dir  input  1  0 = read burst (memory to stream), 1 = write burst (stream to memory).
REQ-010 cmd_addr  input  ADDR_W  burst base word address.
REQ-011 cmd_len  input  LEN_W  burst length in beats; 0 legal.
REQ-012 mem_re / mem_rd_addr  output  1 / ADDR_W  external memory read strobe and address.
REQ-013 mem_rd_data  input  DATA_W  read data, valid the cycle after the mem_re cycle.
REQ-014 mem_we / mem_wr_addr / mem_wr_data  output  1 / ADDR_W / DATA_W  external memory write strobe, address, data.
REQ-015 rd_valid / rd_ready / rd_data / rd_last  out / in / out DATA_W / out  read-data stream.
REQ-016 wr_valid / wr_ready / wr_data  in / out / in DATA_W  write-data stream.
REQ-017 busy  output  1  high whenever state != IDLE.
REQ-018 done  output  1  single-cycle pulse at burst completion.

Function
REQ-019 States IDLE, READ, WRITE, FIN; cmd_ready SHALL be 1 only in IDLE.
REQ-020 On command accept, the block SHALL latch addr/len/dir and go to READ (dir=0, len>0), WRITE (dir=1, len>0) or FIN (len=0).
REQ-021 FIN SHALL last exactly one cycle with done=1, then return to IDLE; no other state asserts done.
REQ-022 READ: mem_re, mem_rd_addr SHALL be registered outputs; beat n is issued at base+n, n = 0..len-1, in increasing order.
REQ-023 mem_rd_data SHALL be captured into an internal 4-entry FIFO in the cycle after the corresponding mem_re cycle.
REQ-024 A read SHALL be issued only when FIFO occupancy plus reads in flight is below 4; the FIFO SHALL never overflow.
REQ-025 With rd_ready held 1, READ SHALL sustain one beat per cycle; the first rd_valid SHALL occur 3 cycles after the accept cycle.
REQ-026 rd_valid = FIFO non-empty; rd_data, rd_last SHALL hold stable while rd_valid && !rd_ready.
REQ-027 rd_last SHALL be 1 only with beat len-1; on its handshake the block SHALL go to FIN.
REQ-028 WRITE: wr_ready SHALL be 1 while accepted beats < len, else 0.
REQ-029 Each wr handshake SHALL produce, next cycle, mem_we=1, mem_wr_addr=base+n, mem_wr_data=wr_data; one write per cycle maximum.
REQ-030 After the mem_we cycle of beat len-1, the block SHALL go to FIN.
REQ-031 Address arithmetic SHALL wrap modulo 2^ADDR_W; beat counters are LEN_W wide.
REQ-032 mem_re and mem_we SHALL never be 1 in the same cycle; neither SHALL assert in IDLE or FIN.
REQ-033 cmd_valid while busy SHALL be ignored with no side effects.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE and cmd_ready=1; busy, done, mem_re, mem_we, rd_valid, rd_last, wr_ready=0; mem_rd_addr, mem_wr_addr, mem_wr_data, rd_data=0.
REQ-035 Reset mid-burst SHALL discard FIFO contents, in-flight reads and counters; the first command after release SHALL behave as from power-up.

Verification
REQ-036 Read len=4, addr 0x10, mem[0x10+i]=i+1, rd_ready=1 -> exactly 4 mem_re at 0x10..0x13, rd_data 1,2,3,4 on consecutive cycles starting accept+3, rd_last with 4, one done pulse.
REQ-037 Read len=6 with rd_ready toggling 1,0,0,1,... -> all 6 beats delivered once, in order, stable under stall, no overflow, mem_re throttled.
REQ-038 Write len=3, addr 0x20, wr_data 0xA,0xB,0xC with wr_valid gaps -> mem_we exactly 3 times at 0x20,0x21,0x22; later read burst returns 0xA,0xB,0xC.
REQ-039 cmd_len=0 (either dir) -> no mem_re/mem_we, done=1 the cycle after accept, cmd_ready=1 the cycle after that.
REQ-040 Read len=4 at addr 2^ADDR_W-2 -> addresses 2^ADDR_W-2, 2^ADDR_W-1, 0, 1.
REQ-041 rst_n pulsed low after 2 beats of an 8-beat read -> outputs at reset values during reset, no further rd_valid; next len=2 read completes correctly.
